// File: rtl/pulse_record_buffer_pkg.sv
// Shared constants for the pulse record buffer: command bytes, record layout
// and the byte-select helper used by the serialiser.
package pulse_pkg;

    localparam int REC_W      = 32;
    localparam int CH_W       = 4;
    localparam int TS_FIELD_W = 28;
    localparam int CH_LSB     = 28;

    localparam logic [CH_W-1:0]  MARKER_CH  = 4'hF;
    localparam logic [REC_W-1:0] MARKER_REC = {MARKER_CH, {TS_FIELD_W{1'b0}}};

    localparam logic [7:0] CMD_NONE    = 8'h00;
    localparam logic [7:0] CMD_ARM     = 8'h01;
    localparam logic [7:0] CMD_DISARM  = 8'h02;
    localparam logic [7:0] CMD_FLUSH   = 8'h03;
    localparam logic [7:0] CMD_CLRDROP = 8'h04;

    // Byte 0 is the most significant byte of the record.
    function automatic logic [7:0] rec_byte(input logic [REC_W-1:0] rec, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = rec[31:24];
            2'd1:    b = rec[23:16];
            2'd2:    b = rec[15:8];
            default: b = rec[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock show-ahead FIFO: the head entry is visible while not empty.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sync_fifo_fwft #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
        end
    end

    // Storage carries no reset; stale entries are never visible past the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
    end

endmodule

// File: rtl/pulse_record_buffer.sv
// Timestamps pulse events, buffers {channel, ts} records and serialises them
// MSB-first as bytes toward the FX2 USB stage.
module pulse_record_buffer
    import pulse_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int TS_BITS    = 28
) (
    input  logic        FX2_CLK,
    input  logic        RST_N,
    input  logic        PULSE_VALID,
    input  logic [3:0]  PULSE_CHANNEL,
    input  logic [7:0]  PCINSTRUCTION,
    input  logic        REQUEST_LENGTH,
    input  logic        FPGA_WORD_ACCEPTED,
    output logic [7:0]  FPGA_WORD,
    output logic        FPGA_WORD_AVAILIABLE,
    output logic [15:0] LENGTH,
    output logic        ARMED,
    output logic [15:0] DROP_COUNT
);

    logic [TS_BITS-1:0] ts_q;
    logic               marker_pending;
    logic [1:0]         byte_idx;
    logic [15:0]        byte_cnt;
    logic [15:0]        cnt_sat;
    logic [15:0]        length_q;
    logic               armed_q;
    logic [15:0]        drop_q;

    logic               is_arm, is_disarm, is_flush, is_clrdrop;
    logic               honoured, pulse_ok, push_req, drop_evt, ts_wrap, marker_sent;
    logic               fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [REC_W-1:0]   fifo_wdata, fifo_head;

    assign is_arm     = (PCINSTRUCTION == CMD_ARM);
    assign is_disarm  = (PCINSTRUCTION == CMD_DISARM);
    assign is_flush   = (PCINSTRUCTION == CMD_FLUSH);
    assign is_clrdrop = (PCINSTRUCTION == CMD_CLRDROP);

    assign honoured = FPGA_WORD_ACCEPTED && !fifo_empty;
    assign pulse_ok = PULSE_VALID && (PULSE_CHANNEL != MARKER_CH);
    assign push_req = armed_q && !is_flush && (pulse_ok || marker_pending);
    assign fifo_rd  = honoured && (byte_idx == 2'd3);
    assign fifo_wr  = push_req && (!fifo_full || fifo_rd);
    assign ts_wrap  = armed_q && (ts_q == {TS_BITS{1'b1}});

    // A marker only goes in on a cycle with no pulse competing for the slot.
    assign marker_sent = fifo_wr && !pulse_ok;
    assign drop_evt    = (PULSE_VALID && (PULSE_CHANNEL == MARKER_CH)) ||
                         (armed_q && !is_flush && pulse_ok && fifo_full && !fifo_rd);
    assign fifo_wdata  = pulse_ok ? {PULSE_CHANNEL, TS_FIELD_W'(ts_q)} : MARKER_REC;

    sync_fifo_fwft #(
        .WIDTH      (REC_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (FX2_CLK),
        .rst_n (RST_N),
        .push  (fifo_wr),
        .wdata (fifo_wdata),
        .pop   (fifo_rd),
        .flush (is_flush),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        cnt_sat = byte_cnt;
        if (honoured && (byte_cnt != 16'hFFFF)) cnt_sat = byte_cnt + 16'd1;
    end

    always_ff @(posedge FX2_CLK or negedge RST_N) begin
        if (!RST_N) begin
            ts_q           <= '0;
            marker_pending <= 1'b0;
        end else if (is_flush) begin
            ts_q           <= '0;
            marker_pending <= 1'b0;
        end else begin
            if (armed_q) ts_q <= ts_q + TS_BITS'(1);
            marker_pending <= (marker_pending && !marker_sent) || ts_wrap;
        end
    end

    always_ff @(posedge FX2_CLK or negedge RST_N) begin
        if (!RST_N) begin
            byte_idx <= 2'd0;
        end else if (is_flush) begin
            byte_idx <= 2'd0;
        end else if (honoured) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // The length snapshot includes an accept landing in the strobe cycle.
    always_ff @(posedge FX2_CLK or negedge RST_N) begin
        if (!RST_N) begin
            byte_cnt <= 16'd0;
            length_q <= 16'd0;
        end else begin
            if (REQUEST_LENGTH) length_q <= cnt_sat;
            byte_cnt <= (REQUEST_LENGTH || is_flush) ? 16'd0 : cnt_sat;
        end
    end

    always_ff @(posedge FX2_CLK or negedge RST_N) begin
        if (!RST_N) begin
            armed_q <= 1'b0;
        end else if (is_arm) begin
            armed_q <= 1'b1;
        end else if (is_disarm) begin
            armed_q <= 1'b0;
        end
    end

    always_ff @(posedge FX2_CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop_q <= 16'd0;
        end else if (is_clrdrop) begin
            drop_q <= drop_evt ? 16'd1 : 16'd0;
        end else if (drop_evt && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign FPGA_WORD_AVAILIABLE = !fifo_empty;
    assign FPGA_WORD            = fifo_empty ? 8'h00 : rec_byte(fifo_head, byte_idx);
    assign LENGTH               = length_q;
    assign ARMED                = armed_q;
    assign DROP_COUNT           = drop_q;

endmodule

// File: doc/pulse_record_buffer.md
Name: pulse_record_buffer

Overview:
- Upstream feeder of the FX2 bidirectional USB stage.
- Timestamps pulse events with a free-running counter and buffers 32-bit records in a FIFO.
- Serialises records MSB-first as bytes through the FPGA_WORD / FPGA_WORD_AVAILIABLE / FPGA_WORD_ACCEPTED handshake.
- Maintains the byte count reported on LENGTH and decodes PC command bytes from PCINSTRUCTION.

Parameters:
- DEPTH_LOG2, 9: record FIFO depth is 2^DEPTH_LOG2 records of 32 bits.
- TS_BITS, 28: timestamp width; record = {channel[3:0], ts[27:0]}.

Ports:
- FX2_CLK  in  1  sole clock, shared with the USB stage.
- RST_N  in  1  asynchronous active-low reset.
- PULSE_VALID  in  1  one-cycle pulse event strobe.
- PULSE_CHANNEL  in  4  channel of the event; 4'hF is reserved and is dropped if supplied.
- PCINSTRUCTION  in  8  command byte; 8'h00 means no command.
- REQUEST_LENGTH  in  1  one-cycle strobe to latch the byte count.
- FPGA_WORD_ACCEPTED  in  1  downstream consumed FPGA_WORD this cycle.
- FPGA_WORD  out  8  current output byte.
- FPGA_WORD_AVAILIABLE  out  1  FPGA_WORD is valid.
- LENGTH  out  16  latched byte count.
- ARMED  out  1  acquisition enabled.
- DROP_COUNT  out  16  records lost, saturating.

Behaviour:
- Reset (async, RST_N low) clears all state:
  - FIFO empty, byte index 0, timestamp 0, count 0.
  - LENGTH=0, ARMED=0, DROP_COUNT=0, FPGA_WORD_AVAILIABLE=0.
  - FPGA_WORD=0 whenever the FIFO is empty.
  - Reset mid-record discards the partial record; no byte is emitted after release until a new record is pushed.
- Timestamp: TS_BITS counter, increments every cycle while ARMED, holds while disarmed.
- Rollover:
  - When the counter wraps to 0 while ARMED, set marker_pending.
  - Marker record = {4'hF, 28'h0}.
- Push arbitration, one push per cycle, only while ARMED:
  - Priority 1: a valid pulse with channel != 4'hF pushes {PULSE_CHANNEL, ts}.
  - Priority 2: otherwise, a pending marker pushes.
  - A marker therefore waits while pulses arrive back-to-back.
  - A push into a full FIFO is discarded and DROP_COUNT increments, saturating at 16'hFFFF.
  - Pulses with PULSE_CHANNEL == 4'hF are always dropped and counted.
  - A marker never drops: it stays pending until space exists.
- FIFO: show-ahead. The head record is visible combinationally.
- FPGA_WORD_AVAILIABLE = FIFO not empty.
- FPGA_WORD = head byte selected by byte index:
  - index 0 = bits 31:24, 1 = 23:16, 2 = 15:8, 3 = 7:0.
- Pop rule:
  - FPGA_WORD_ACCEPTED is sampled on the clock edge.
  - ACCEPTED while AVAILIABLE increments the index.
  - ACCEPTED with index 3 pops the record and returns the index to 0.
  - ACCEPTED while empty is ignored.
- Simultaneous push and pop at full: the pop frees a slot and the push succeeds (no drop).
- Byte counter, 16 bits:
  - Increments on each honoured accept and saturates at 16'hFFFF.
  - On REQUEST_LENGTH: LENGTH <= counter (including an accept in the same cycle), then the counter clears to 0, or to 1 if that same-cycle accept is counted after the clear. Implement exactly: LENGTH <= cnt + acc; cnt <= 0.
  - LENGTH is stable from the cycle after the strobe until the next strobe. The downstream samples it 2-4 cycles later.
- Commands, one per cycle, decoded when PCINSTRUCTION != 0:
  - 8'h01 ARM: ARMED <= 1.
  - 8'h02 DISARM: ARMED <= 0. The FIFO keeps draining.
  - 8'h03 FLUSH: empties the FIFO, index 0, counter 0, marker_pending 0, timestamp 0. ARMED is unchanged. A push in the same cycle is discarded and not counted as a drop.
  - 8'h04 CLRDROP: DROP_COUNT <= 0. A same-cycle drop wins and sets the count to 1.
  - Other values are ignored.
- Latency: a pulse at cycle N gives FPGA_WORD_AVAILIABLE=1 at N+1 if the FIFO was empty.

Decomposition:
- Shared package pulse_pkg:
  - Command constants CMD_ARM=8'h01, CMD_DISARM=8'h02, CMD_FLUSH=8'h03, CMD_CLRDROP=8'h04.
  - MARKER_CH=4'hF, record width 32, record field positions.
- One sub-module: sync_fifo_fwft.
  - Parameterised width/depth, show-ahead, with full, empty and flush.
  - Instantiated once for the records.
- Timestamp, arbitration, serialiser, counters and command decode stay in the top module.

Test Plan:
1. Reset then ARM (8'h01). Pulse ch 3 at ts 0x0000010. Hold ACCEPTED high. Expect bytes 0x30,0x00,0x00,0x10. AVAILIABLE drops after the 4th byte.
2. Fill the FIFO to 512 records, then 3 more pulses with no accepts. Expect DROP_COUNT=3. Then push and pop on the same cycle at full: no drop.
3. Accept 600 bytes, then REQUEST_LENGTH. Expect LENGTH=600 (0x0258). The counter restarts at 0, and a same-cycle accept gives LENGTH=601.
4. Force the timestamp near wrap with a pulse on the wrap cycle. Expect the pulse record first, then marker bytes 0xF0,0x00,0x00,0x00.
5. With 2 bytes of a record consumed, send FLUSH. Expect AVAILIABLE=0 next cycle, counter 0, ARMED still 1. Next pulse emits from byte 0.
6. Assert RST_N low asynchronously mid-record. All outputs are 0 immediately. After release, pulses are ignored until ARM is sent.
